mezzanina_gigafitter_core: RTL and testbench
============================================

# mezzanina_gigafitter_core

Input-stage receiver for the Gigafitter mezzanine. It accepts 23-bit SVT-format words (hits, end-of-road, end-event) on the W1 bus. Words are buffered in a 16-deep FIFO and forwarded to the J1 output bus under a downstream hold. The block also tracks end-event tags, event counts and error flags for board monitoring.

## Interface
Parameters:
- FIFO_DEPTH, 16: input FIFO entries (power of two).
- HOLD_LEVEL, 12: fill level at which W_HOLD_2 asserts.

Ports:
- J3WRITECLK  in  1  sole clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- W1_DATA  in  24  [22:0] word, [23] DS_N strobe, active-low.
- W_HOLD_2  out  1  upstream hold.
- J1DATA_out  out  24  [23:1] forwarded word, [24] word-valid.
- J1DATA_25  in  1  downstream hold, active-high.
- OUT  out  20  [8:1] last end-event tag, [20:9] event count.
- FLOATIN_3  out  1  sticky FIFO-overflow flag.
- FLOATIN_4  out  1  sticky tag-sequence-error flag.
- J3DATA_out_24  out  1  end-event pulse.
- J3DATA_in  in  9  [15] synchronous clear of flags and counters; [23:16] reserved, ignored.
- J1DATA  inout  20  [45:26]; always high-Z.
- J3DATA  inout  14  [14:1]; high-Z unless debug is enabled.

## Operation
- Word fields: bit 22 = EE (end event), bit 21 = EP (end of road), bits [7:0] of an EE word = event tag. Words with bit 22 = 0 are data or EP words.
- Write: on any edge with DS_N = 0, W1_DATA[22:0] is pushed into the FIFO. If the FIFO is full at that edge, the word is dropped and FLOATIN_3 sets. Fullness is evaluated before the same-cycle read.
- Read: on any edge with the FIFO non-empty and J1DATA_25 = 0, the head word is popped into J1DATA_out[23:1] and J1DATA_out[24] = 1. Otherwise J1DATA_out[24] = 0 and [23:1] holds its last value.
- Hold: W_HOLD_2 is registered and equals 1 when the fill level is at least HOLD_LEVEL.
- End event, evaluated when an EE word is emitted:
  - OUT[8:1] takes the tag.
  - OUT[20:9] increments; it wraps 4095 to 0.
  - J3DATA_out_24 pulses high for one cycle.
- Tag check:
  - The first EE word after reset or clear is not checked.
  - Each later tag must equal the previous tag + 1 mod 256. A mismatch sets FLOATIN_4.
- Clear: J3DATA_in[15] = 1 at an edge zeroes OUT, FLOATIN_3, FLOATIN_4 and the tag-check history. It does not flush the FIFO. If clear and an EE emission occur in the same cycle, the clear wins for counters.
- Reset:
  - FIFO empty.
  - All outputs 0: W_HOLD_2, J1DATA_out, OUT, FLOATIN_3, FLOATIN_4, J3DATA_out_24.
  - Bidirs high-Z.
  - Reset mid-stream discards buffered words.

## Timing
- Latency: a word sampled at edge N, with the FIFO empty and no hold, is on J1DATA_out with valid = 1 after edge N+1, for one cycle.
- Throughput is one word per clock in and one word per clock out.
- The EE pulse, tag, count and FLOATIN_4 update all take effect after the same edge as the EE word's emission.
- W_HOLD_2 lags the fill level by one cycle. The upstream must honour hold within 4 words (the FIFO headroom).

## Configuration
- GF_DEBUG_BUS_EN defined: J3DATA[14:1] is driven continuously.
  - [6:1] = FIFO fill level.
  - [14:7] = number of words emitted in the current event, saturating at 255 and reset after each EE word.
- GF_DEBUG_BUS_EN undefined: J3DATA is high-Z and the debug logic is absent.

## Structure
- Shared package gf_pkg: word-field bit positions (EE_BIT = 22, EP_BIT = 21, TAG_MSB = 7), word width 23, FIFO_DEPTH and HOLD_LEVEL defaults.
- One sub-module, gf_sync_fifo: synchronous FIFO with push, pop, full, empty and level outputs. The top level holds the output register, the EE/tag/counter logic and the bidir tri-states.

## Test plan
- Reset, then stream 0x00cc0c, 0x0539da, 0x081a25, 0x600001 with one word per clock and no hold -> the same words on J1DATA_out one cycle later. OUT = {12'd1, 8'h01} and one J3DATA_out_24 pulse.
- Three events with tags 1, 2, 3 (EE words 0x600001, 0x600002, 0x600003) -> OUT[20:9] = 3, OUT[8:1] = 0x03, FLOATIN_4 = 0.
- Tags 1 then 3 -> FLOATIN_4 = 1 after the second EE word. Pulse J3DATA_in[15] -> FLOATIN_4 = 0 and OUT = 0.
- Hold J1DATA_25 = 1 and write 12 words -> W_HOLD_2 = 1 one cycle after the 12th push. Write 5 more -> the 17th is dropped and FLOATIN_3 = 1. Release hold -> exactly 16 words out, in order.
- EP word 0x287e23 followed by 0x600002 -> both forwarded unchanged. EP does not trigger an end-event pulse.
- Assert RST mid-stream with 5 words buffered -> outputs 0 immediately and nothing is emitted after release.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared definitions for the Gigafitter input-stage receiver: SVT word
// field positions, word width and default buffer sizing.
package gf_pkg;

  localparam int WORD_W         = 23;
  localparam int EE_BIT         = 22;
  localparam int EP_BIT         = 21;
  localparam int TAG_MSB        = 7;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int HOLD_LEVEL_DEF = 12;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [TAG_MSB:0]  tag_t;

  function automatic logic is_ee(input word_t w);
    return w[EE_BIT];
  endfunction

  function automatic logic is_ep(input word_t w);
    return w[EP_BIT] & ~w[EE_BIT];
  endfunction

  function automatic tag_t tag_of(input word_t w);
    return w[TAG_MSB:0];
  endfunction

endpackage

// File: rtl/gf_sync_fifo.sv
// Single-clock FIFO with registered fill level. A push while full and a pop
// while empty are ignored, so the caller may drive raw requests.
module gf_sync_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; no reset needed since occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and fill-level bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mezzanina_gigafitter_core.sv
// Gigafitter mezzanine input stage: buffers SVT words from W1, forwards them
// to J1 under downstream hold, and tracks end-event tags, event count and
// sticky error flags. Optional debug bus on J3 enabled by GF_DEBUG_BUS_EN.
module mezzanina_gigafitter_core
  import gf_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int HOLD_LEVEL = HOLD_LEVEL_DEF
) (
  input  logic          J3WRITECLK,
  input  logic          RST,
  input  logic [23:0]   W1_DATA,
  output logic          W_HOLD_2,
  output logic [24:1]   J1DATA_out,
  input  logic          J1DATA_25,
  output logic [20:1]   OUT,
  output logic          FLOATIN_3,
  output logic          FLOATIN_4,
  output logic          J3DATA_out_24,
  input  logic [23:15]  J3DATA_in,
  inout  wire  [45:26]  J1DATA,
  inout  wire  [14:1]   J3DATA
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] HOLD_L = (AW+1)'(HOLD_LEVEL);

  logic        ds_n;
  word_t       in_word;
  word_t       head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_level;
  logic        push;
  logic        pop;
  logic        emit_ee;
  logic        clr;

  word_t       word_q;
  logic        valid_q;
  tag_t        last_tag;
  logic [11:0] ee_count;
  logic        have_tag;

  // Reserved clear-register bits are deliberately ignored.
  wire unused_j3_in = &{1'b0, J3DATA_in[23:16]};

  assign ds_n    = W1_DATA[23];
  assign in_word = W1_DATA[WORD_W-1:0];
  assign push    = ~ds_n;
  assign pop     = ~fifo_empty & ~J1DATA_25;
  assign emit_ee = pop & is_ee(head);
  assign clr     = J3DATA_in[15];

  gf_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (J3WRITECLK),
    .rst     (RST),
    .push    (push),
    .wr_data (in_word),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Output register: the popped word holds until the next pop; valid is a
  // single-cycle qualifier. Hold is the fill level registered once.
  always_ff @(posedge J3WRITECLK or posedge RST) begin
    if (RST) begin
      word_q   <= '0;
      valid_q  <= 1'b0;
      W_HOLD_2 <= 1'b0;
    end else begin
      valid_q  <= pop;
      if (pop) word_q <= head;
      W_HOLD_2 <= (fifo_level >= HOLD_L);
    end
  end

  // End-event tracking and sticky flags. Clear beats a same-cycle EE update
  // for the counters/flags, but the EE pulse itself still fires.
  always_ff @(posedge J3WRITECLK or posedge RST) begin
    if (RST) begin
      last_tag      <= '0;
      ee_count      <= '0;
      have_tag      <= 1'b0;
      FLOATIN_3     <= 1'b0;
      FLOATIN_4     <= 1'b0;
      J3DATA_out_24 <= 1'b0;
    end else begin
      J3DATA_out_24 <= emit_ee;
      if (clr) begin
        last_tag  <= '0;
        ee_count  <= '0;
        have_tag  <= 1'b0;
        FLOATIN_3 <= 1'b0;
        FLOATIN_4 <= 1'b0;
      end else begin
        if (~ds_n & fifo_full) FLOATIN_3 <= 1'b1;
        if (emit_ee) begin
          last_tag <= tag_of(head);
          ee_count <= ee_count + 12'd1;
          have_tag <= 1'b1;
          if (have_tag && (tag_of(head) != last_tag + 8'd1)) FLOATIN_4 <= 1'b1;
        end
      end
    end
  end

  assign J1DATA_out = {valid_q, word_q};
  assign OUT        = {ee_count, last_tag};
  assign J1DATA     = 'z;

`ifdef GF_DEBUG_BUS_EN
  logic [7:0] evt_words;

  // Words emitted in the current event, saturating; an EE word restarts it.
  always_ff @(posedge J3WRITECLK or posedge RST) begin
    if (RST) begin
      evt_words <= '0;
    end else if (pop) begin
      if (is_ee(head))              evt_words <= '0;
      else if (evt_words != 8'hff)  evt_words <= evt_words + 8'd1;
    end
  end

  assign J3DATA = {evt_words, 6'(fifo_level)};
`else
  assign J3DATA = 'z;
`endif

endmodule

// File: tb/tb_mezzanina_gigafitter_core.sv
// Directed bench for mezzanina_gigafitter_core: a vector table for the
// streaming/end-event/tag-check behaviour plus hand-written hold, overflow
// and mid-stream reset sequences.
module tb_mezzanina_gigafitter_core;

  logic         clk;
  logic         rst;
  logic [23:0]  w1;
  logic         hold;
  logic [23:15] j3in;
  logic         whold;
  logic [24:1]  j1out;
  logic [20:1]  outv;
  logic         f3;
  logic         f4;
  logic         pulse;
  wire  [45:26] j1data;
  wire  [14:1]  j3data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [23:0] IDLE = 24'h800000;

  mezzanina_gigafitter_core dut (
    .J3WRITECLK    (clk),
    .RST           (rst),
    .W1_DATA       (w1),
    .W_HOLD_2      (whold),
    .J1DATA_out    (j1out),
    .J1DATA_25     (hold),
    .OUT           (outv),
    .FLOATIN_3     (f3),
    .FLOATIN_4     (f4),
    .J3DATA_out_24 (pulse),
    .J3DATA_in     (j3in),
    .J1DATA        (j1data),
    .J3DATA        (j3data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] w1;
    logic        hold;
    logic        clr;
    logic        ev;
    logic [22:0] ew;
    logic [19:0] eout;
    logic        ep;
    logic        ef4;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int got;
    int nval;
    logic [22:0] exp_w;

    // inputs -> expected state after the following rising edge
    vt[0]  = '{24'h00cc0c, 1'b0, 1'b0, 1'b0, 23'h000000, 20'h00000, 1'b0, 1'b0};
    vt[1]  = '{24'h0539da, 1'b0, 1'b0, 1'b1, 23'h00cc0c, 20'h00000, 1'b0, 1'b0};
    vt[2]  = '{24'h081a25, 1'b0, 1'b0, 1'b1, 23'h0539da, 20'h00000, 1'b0, 1'b0};
    vt[3]  = '{24'h600001, 1'b0, 1'b0, 1'b1, 23'h081a25, 20'h00000, 1'b0, 1'b0};
    vt[4]  = '{IDLE,       1'b0, 1'b0, 1'b1, 23'h600001, 20'h00101, 1'b1, 1'b0};
    vt[5]  = '{IDLE,       1'b0, 1'b0, 1'b0, 23'h600001, 20'h00101, 1'b0, 1'b0};
    vt[6]  = '{24'h600002, 1'b0, 1'b0, 1'b0, 23'h600001, 20'h00101, 1'b0, 1'b0};
    vt[7]  = '{IDLE,       1'b0, 1'b0, 1'b1, 23'h600002, 20'h00202, 1'b1, 1'b0};
    vt[8]  = '{24'h600003, 1'b0, 1'b0, 1'b0, 23'h600002, 20'h00202, 1'b0, 1'b0};
    vt[9]  = '{IDLE,       1'b0, 1'b0, 1'b1, 23'h600003, 20'h00303, 1'b1, 1'b0};
    vt[10] = '{IDLE,       1'b0, 1'b1, 1'b0, 23'h600003, 20'h00000, 1'b0, 1'b0};
    vt[11] = '{24'h600001, 1'b0, 1'b0, 1'b0, 23'h600003, 20'h00000, 1'b0, 1'b0};
    vt[12] = '{24'h600003, 1'b0, 1'b0, 1'b1, 23'h600001, 20'h00101, 1'b1, 1'b0};
    vt[13] = '{IDLE,       1'b0, 1'b0, 1'b1, 23'h600003, 20'h00203, 1'b1, 1'b1};
    vt[14] = '{IDLE,       1'b0, 1'b1, 1'b0, 23'h600003, 20'h00000, 1'b0, 1'b0};
    vt[15] = '{24'h287e23, 1'b0, 1'b0, 1'b0, 23'h600003, 20'h00000, 1'b0, 1'b0};
    vt[16] = '{24'h600002, 1'b0, 1'b0, 1'b1, 23'h287e23, 20'h00000, 1'b0, 1'b0};
    vt[17] = '{IDLE,       1'b0, 1'b0, 1'b1, 23'h600002, 20'h00102, 1'b1, 1'b0};
    vt[18] = '{IDLE,       1'b0, 1'b0, 1'b0, 23'h600002, 20'h00102, 1'b0, 1'b0};

    rst  = 1'b1;
    w1   = IDLE;
    hold = 1'b0;
    j3in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset J1DATA_out", 32'(j1out), 32'h0);
    check("reset OUT",        32'(outv),  32'h0);
    check("reset W_HOLD_2",   32'(whold), 32'h0);
    check("reset FLOATIN_3",  32'(f3),    32'h0);
    check("reset FLOATIN_4",  32'(f4),    32'h0);
    check("reset pulse",      32'(pulse), 32'h0);
    rst = 1'b0;

    for (int r = 0; r < NV; r++) begin
      w1   = vt[r].w1;
      hold = vt[r].hold;
      j3in = {8'ha5, vt[r].clr};
      tick();
      check($sformatf("row%0d valid", r),    32'(j1out[24]),   32'(vt[r].ev));
      check($sformatf("row%0d word", r),     32'(j1out[23:1]), 32'(vt[r].ew));
      check($sformatf("row%0d OUT", r),      32'(outv),        32'(vt[r].eout));
      check($sformatf("row%0d pulse", r),    32'(pulse),       32'(vt[r].ep));
      check($sformatf("row%0d FLOATIN_4", r), 32'(f4),         32'(vt[r].ef4));
      check($sformatf("row%0d FLOATIN_3", r), 32'(f3),         32'h0);
    end
    w1   = IDLE;
    j3in = '0;
    tick();

    // Hold downstream, fill to 16, overflow on the 17th push.
    hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      w1 = {1'b0, 23'h000100 + 23'(i)};
      tick();
      if (i == 11) check("hold lags 12th push", 32'(whold), 32'h0);
      if (i == 12) check("hold after 12th push", 32'(whold), 32'h1);
      if (i == 15) check("no overflow at 16", 32'(f3), 32'h0);
      if (i == 16) begin
        check("overflow at 17", 32'(f3), 32'h1);
        check("no output under hold", 32'(j1out[24]), 32'h0);
      end
    end
    w1   = IDLE;
    hold = 1'b0;
    got  = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (j1out[24]) begin
        exp_w = 23'h000100 + 23'(got);
        check($sformatf("drain word %0d", got), 32'(j1out[23:1]), 32'(exp_w));
        got++;
      end
    end
    check("drain count", 32'(got), 32'd16);
    check("hold released", 32'(whold), 32'h0);

    // Reset with buffered words: outputs drop at once, nothing emitted.
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w1 = {1'b0, 23'h000200 + 23'(i)};
      tick();
    end
    w1 = IDLE;
    tick();
    check("pre-reset OUT", 32'(outv), 32'h00102);
    rst = 1'b1;
    #1;
    check("async reset J1DATA_out", 32'(j1out), 32'h0);
    check("async reset OUT",        32'(outv),  32'h0);
    check("async reset FLOATIN_3",  32'(f3),    32'h0);
    check("async reset W_HOLD_2",   32'(whold), 32'h0);
    tick();
    rst  = 1'b0;
    hold = 1'b0;
    nval = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (j1out[24]) nval++;
    end
    check("no words after reset", 32'(nval), 32'h0);

    // Single EE word after reset: one-cycle latency, first tag unchecked.
    w1 = 24'h600005;
    tick();
    w1 = IDLE;
    check("post-reset push no valid", 32'(j1out[24]), 32'h0);
    tick();
    check("post-reset valid", 32'(j1out[24]),   32'h1);
    check("post-reset word",  32'(j1out[23:1]), 32'h600005);
    check("post-reset OUT",   32'(outv),        32'h00105);
    check("post-reset pulse", 32'(pulse),       32'h1);
    check("post-reset FLOATIN_4", 32'(f4),      32'h0);
    tick();
    check("post-reset pulse ends", 32'(pulse), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
